// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO built from a register array. The head entry is read
// straight out of the array, so no extra output stage adds latency.
module sync_fifo #(
  parameter int unsigned WIDTH = 161,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             push_ok
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;

  // The extra pointer MSB tells full from empty when the index bits coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, a same-cycle push overwrites the slot being popped; the pop reads
  // the old contents before the edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/data_to_axi_stream_buffer.sv
// Buffers fixed-width trace packets and emits them as an AXI4-Stream master,
// marking frame ends every tlast_interval packets or on a forced tlast.
module data_to_axi_stream_buffer #(
  parameter int unsigned DATA_WIDTH = 160,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_pkt,
  input  logic [31:0]           tlast_interval,
  input  logic                  tlast,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                  M_AXIS_tlast
);
  logic [31:0]         cnt;
  logic                last;
  logic                push_ok;
  logic                empty;
  logic                full;
  logic [DATA_WIDTH:0] fifo_out;

  // Widened compare so cnt + 1 cannot wrap; ">=" closes the frame at once if the
  // interval shrinks below the running count.
  always_comb begin
    last = tlast;
    if ((tlast_interval != 32'd0) && (({1'b0, cnt} + 33'd1) >= {1'b0, tlast_interval}))
      last = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (push_ok) cnt <= last ? '0 : cnt + 32'd1;
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (write_enable),
    .din     ({last, data_pkt}),
    .pop     (M_AXIS_tready),
    .dout    (fifo_out),
    .empty   (empty),
    .full    (full),
    .push_ok (push_ok)
  );

  assign M_AXIS_tvalid = !empty;
  assign M_AXIS_tdata  = fifo_out[DATA_WIDTH-1:0];
  assign M_AXIS_tlast  = fifo_out[DATA_WIDTH];
endmodule

// File: tb/tb_data_to_axi_stream_buffer.sv
// Self-checking bench for data_to_axi_stream_buffer: a table of per-cycle vectors
// plus hand-written backpressure and full-buffer sequences.
module tb_data_to_axi_stream_buffer;
  localparam int unsigned DW = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enable;
  logic [DW-1:0] data_pkt;
  logic [31:0]   tlast_interval;
  logic          tlast;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [DW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;

  int n_checks = 0;
  int n_fail   = 0;

  data_to_axi_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .write_enable   (write_enable),
    .data_pkt       (data_pkt),
    .tlast_interval (tlast_interval),
    .tlast          (tlast),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tlast   (M_AXIS_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          we;
    logic          frc;
    logic          rdy;
    logic [31:0]   ivl;
    logic [DW-1:0] data;
    logic          ev;
    logic          chk_d;
    logic [DW-1:0] ed;
    logic          el;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic we, input logic frc,
                              input logic rdy, input logic [31:0] ivl,
                              input logic [DW-1:0] d, input logic ev,
                              input logic chk_d, input logic [DW-1:0] ed,
                              input logic el);
    vec_t v;
    v.rst = r; v.we = we; v.frc = frc; v.rdy = rdy; v.ivl = ivl; v.data = d;
    v.ev = ev; v.chk_d = chk_d; v.ed = ed; v.el = el;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [DW-1:0] d,
                       input logic frc, input logic [31:0] ivl, input logic rdy);
    rst = r; write_enable = we; data_pkt = d; tlast = frc;
    tlast_interval = ivl; M_AXIS_tready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 32'd0, 1'b0);

    // Reset latency: two reset cycles, push 0xA, visible one cycle later, then drained.
    add(1, 0, 0, 1, 0, '0, 0, 1, '0, 0);
    add(1, 0, 0, 1, 0, '0, 0, 1, '0, 0);
    add(0, 1, 0, 1, 0, DW'(32'hA), 1, 1, DW'(32'hA), 0);
    add(0, 0, 0, 1, 0, '0, 0, 0, '0, 0);

    // Interval tlast every 4 packets.
    add(1, 0, 0, 1, 0, '0, 0, 1, '0, 0);
    for (int i = 1; i <= 10; i++)
      add(0, 1, 0, 1, 32'd4, DW'(i), 1, 1, DW'(i), (i == 4) || (i == 8));

    // Forced tlast restarts the count.
    add(1, 0, 0, 1, 0, '0, 0, 1, '0, 0);
    for (int i = 1; i <= 6; i++)
      add(0, 1, (i == 2), 1, 32'd4, DW'(32'h20 + i), 1, 1, DW'(32'h20 + i),
          (i == 2) || (i == 6));

    // Interval disabled: only a forced flag closes a frame.
    add(1, 0, 0, 1, 0, '0, 0, 1, '0, 0);
    for (int i = 1; i <= 40; i++)
      add(0, 1, 0, 1, 32'd0, DW'(32'h1000 + i), 1, 1, DW'(32'h1000 + i), 0);
    add(0, 1, 1, 1, 32'd0, DW'(32'h2000), 1, 1, DW'(32'h2000), 1);
    add(0, 1, 0, 1, 32'd0, DW'(32'h2001), 1, 1, DW'(32'h2001), 0);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].we, vq[k].data, vq[k].frc, vq[k].ivl, vq[k].rdy);
      step();
      check($sformatf("vec%0d_tvalid", k), DW'(M_AXIS_tvalid), DW'(vq[k].ev));
      if (vq[k].chk_d)
        check($sformatf("vec%0d_tdata", k), M_AXIS_tdata, vq[k].ed);
      check($sformatf("vec%0d_tlast", k), DW'(M_AXIS_tlast), DW'(vq[k].el));
    end

    // Backpressure: fill 16, two more are dropped, head stays stable, drain in order.
    drive(1, 0, '0, 0, 32'd0, 0); step();
    for (int i = 0; i < 18; i++) begin
      drive(0, 1, DW'(32'h100 + i), 0, 32'd0, 0);
      step();
      check($sformatf("bp_fill%0d_tvalid", i), DW'(M_AXIS_tvalid), DW'(1));
      check($sformatf("bp_fill%0d_tdata", i), M_AXIS_tdata, DW'(32'h100));
    end
    drive(0, 0, '0, 0, 32'd0, 1);
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("bp_drain%0d_tvalid", i), DW'(M_AXIS_tvalid), DW'(1));
      check($sformatf("bp_drain%0d_tdata", i), M_AXIS_tdata, DW'(32'h100 + i));
      check($sformatf("bp_drain%0d_tlast", i), DW'(M_AXIS_tlast), DW'(0));
      step();
    end
    check("bp_empty_tvalid", DW'(M_AXIS_tvalid), DW'(0));

    // Full with simultaneous push/pop: the push lands and occupancy stays 16,
    // proven by a following push being dropped.
    drive(1, 0, '0, 0, 32'd0, 0); step();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, DW'(32'h300 + i), 0, 32'd0, 0);
      step();
    end
    drive(0, 1, DW'(32'h3FF), 0, 32'd0, 1); step();
    check("full_pushpop_head", M_AXIS_tdata, DW'(32'h301));
    drive(0, 1, DW'(32'h3EE), 0, 32'd0, 0); step();
    check("full_drop_head", M_AXIS_tdata, DW'(32'h301));
    drive(0, 0, '0, 0, 32'd0, 1);
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] exp_d;
      exp_d = (i < 15) ? DW'(32'h301 + i) : DW'(32'h3FF);
      #1;
      check($sformatf("full_drain%0d_tvalid", i), DW'(M_AXIS_tvalid), DW'(1));
      check($sformatf("full_drain%0d_tdata", i), M_AXIS_tdata, exp_d);
      step();
    end
    check("full_empty_tvalid", DW'(M_AXIS_tvalid), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
